// File: rtl/wb_arbiter_pkg.sv
// Shared types and constants for the writeback arbiter and its scoreboard.
package wb_arbiter_pkg;

  localparam int ADDR_WIDTH = 5;
  localparam int DATA_WIDTH = 32;

  localparam logic [ADDR_WIDTH-1:0] ZERO_REG = '0;

  typedef struct packed {
    logic                  valid;
    logic [ADDR_WIDTH-1:0] rd;
    logic [DATA_WIDTH-1:0] data;
  } wb_req_t;

endpackage

// File: rtl/wb_scoreboard.sv
// Per-register pending-write bits with one set port, one clear port and two lookups.
module wb_scoreboard
  import wb_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH = wb_arbiter_pkg::ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  set_i,
  input  logic [ADDR_WIDTH-1:0] set_addr_i,
  input  logic                  clr_i,
  input  logic [ADDR_WIDTH-1:0] clr_addr_i,
  input  logic [ADDR_WIDTH-1:0] raddr1_i,
  input  logic [ADDR_WIDTH-1:0] raddr2_i,
  output logic                  busy1_o,
  output logic                  busy2_o
);

  localparam int NREGS = 2 ** ADDR_WIDTH;

  logic [NREGS-1:0] busy_q;
  logic [NREGS-1:0] busy_d;

  // Set is applied after clear so a same-cycle issue to a retiring register stays busy.
  always_comb begin
    busy_d = busy_q;
    if (clr_i && clr_addr_i != ZERO_REG) busy_d[clr_addr_i] = 1'b0;
    if (set_i && set_addr_i != ZERO_REG) busy_d[set_addr_i] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) busy_q <= '0;
    else     busy_q <= busy_d;
  end

  assign busy1_o = busy_q[raddr1_i];
  assign busy2_o = busy_q[raddr2_i];

endmodule

// File: rtl/wb_arbiter.sv
// Writeback stage: arbitrates execute/LSU results onto the register-file write port,
// tracks pending writes and forwards the in-flight write to decode.
module wb_arbiter
  import wb_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH   = wb_arbiter_pkg::ADDR_WIDTH,
  parameter int DATA_WIDTH   = wb_arbiter_pkg::DATA_WIDTH,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  src0_valid,
  output logic                  src0_ready,
  input  logic [ADDR_WIDTH-1:0] src0_rd,
  input  logic [DATA_WIDTH-1:0] src0_data,
  input  logic                  src1_valid,
  output logic                  src1_ready,
  input  logic [ADDR_WIDTH-1:0] src1_rd,
  input  logic [DATA_WIDTH-1:0] src1_data,
  input  logic                  iss_valid,
  input  logic [ADDR_WIDTH-1:0] iss_rd,
  output logic                  rf_wen,
  output logic [ADDR_WIDTH-1:0] rf_waddr,
  output logic [DATA_WIDTH-1:0] rf_wdata,
  input  logic [ADDR_WIDTH-1:0] raddr1,
  input  logic [ADDR_WIDTH-1:0] raddr2,
  output logic                  fwd1_valid,
  output logic                  fwd2_valid,
  output logic [DATA_WIDTH-1:0] fwd1_data,
  output logic [DATA_WIDTH-1:0] fwd2_data,
  output logic                  busy1,
  output logic                  busy2
);

  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] STARVE_MAX = CNT_W'(STARVE_LIMIT);

  logic [CNT_W-1:0]      starve_q, starve_d;
  logic                  rf_wen_q, rf_wen_d;
  logic [ADDR_WIDTH-1:0] rf_waddr_q, rf_waddr_d;
  logic [DATA_WIDTH-1:0] rf_wdata_q, rf_wdata_d;

  logic                  grant0, grant1, xfer;
  logic [ADDR_WIDTH-1:0] win_rd;
  logic [DATA_WIDTH-1:0] win_data;
  logic                  sb_busy1, sb_busy2;

  // src0 has priority unless src1 has been denied for STARVE_LIMIT cycles in a row.
  always_comb begin
    grant1   = src1_valid && (!src0_valid || starve_q == STARVE_MAX);
    grant0   = src0_valid && !grant1;
    xfer     = grant0 || grant1;
    win_rd   = grant1 ? src1_rd   : src0_rd;
    win_data = grant1 ? src1_data : src0_data;

    starve_d = '0;
    if (src1_valid && !grant1)
      starve_d = (starve_q == STARVE_MAX) ? starve_q : starve_q + 1'b1;

    rf_wen_d   = xfer && win_rd != ZERO_REG;
    rf_waddr_d = xfer ? win_rd   : rf_waddr_q;
    rf_wdata_d = xfer ? win_data : rf_wdata_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      starve_q   <= '0;
      rf_wen_q   <= 1'b0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
    end else begin
      starve_q   <= starve_d;
      rf_wen_q   <= rf_wen_d;
      rf_waddr_q <= rf_waddr_d;
      rf_wdata_q <= rf_wdata_d;
    end
  end

  wb_scoreboard #(.ADDR_WIDTH(ADDR_WIDTH)) u_scoreboard (
    .clk        (clk),
    .rst        (rst),
    .set_i      (iss_valid),
    .set_addr_i (iss_rd),
    .clr_i      (xfer),
    .clr_addr_i (win_rd),
    .raddr1_i   (raddr1),
    .raddr2_i   (raddr2),
    .busy1_o    (sb_busy1),
    .busy2_o    (sb_busy2)
  );

  assign src0_ready = grant0;
  assign src1_ready = grant1;
  assign rf_wen     = rf_wen_q;
  assign rf_waddr   = rf_waddr_q;
  assign rf_wdata   = rf_wdata_q;

  // A register whose write is on the port this cycle is bypassed rather than stalled.
  assign fwd1_valid = rf_wen_q && rf_waddr_q == raddr1 && raddr1 != ZERO_REG;
  assign fwd2_valid = rf_wen_q && rf_waddr_q == raddr2 && raddr2 != ZERO_REG;
  assign fwd1_data  = rf_wdata_q;
  assign fwd2_data  = rf_wdata_q;
  assign busy1      = sb_busy1 && !fwd1_valid;
  assign busy2      = sb_busy2 && !fwd2_valid;

endmodule
